// File: rtl/div_div.sv
// Sequential restoring radix-2 unsigned divider, one quotient bit per clock.
// Optional remainder output is enabled by defining DIVDIV_REMAINDER_EN.
module div_div #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             enable,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
`ifdef DIVDIV_REMAINDER_EN
    output logic [WIDTH-1:0] remainder,
`endif
    output logic [WIDTH-1:0] result
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t           state_reg;
    logic             enable_d_reg;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] d_reg;
    logic [WIDTH-1:0] rem_reg;
    logic [CW-1:0]    cnt_reg;
    logic [WIDTH-1:0] result_reg;
`ifdef DIVDIV_REMAINDER_EN
    logic [WIDTH-1:0] remainder_reg;
`endif

    logic             start;
    logic [WIDTH:0]   rem_sh;
    logic             fits;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] q_next;

    // The partial remainder is always below the divisor, so it fits in WIDTH
    // bits; only the shifted value needs the extra bit for the compare.
    always_comb begin
        start    = enable & ~enable_d_reg;
        rem_sh   = {rem_reg, q_reg[WIDTH-1]};
        fits     = (rem_sh >= {1'b0, d_reg});
        rem_next = fits ? WIDTH'(rem_sh - {1'b0, d_reg}) : rem_sh[WIDTH-1:0];
        q_next   = (q_reg << 1) | WIDTH'(fits);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg     <= IDLE;
            enable_d_reg  <= 1'b0;
            q_reg         <= '0;
            d_reg         <= '0;
            rem_reg       <= '0;
            cnt_reg       <= '0;
            result_reg    <= '0;
`ifdef DIVDIV_REMAINDER_EN
            remainder_reg <= '0;
`endif
        end else begin
            enable_d_reg <= enable;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        if (divisor == '0) begin
                            result_reg    <= '1;
`ifdef DIVDIV_REMAINDER_EN
                            remainder_reg <= dividend;
`endif
                        end else begin
                            q_reg     <= dividend;
                            d_reg     <= divisor;
                            rem_reg   <= '0;
                            cnt_reg   <= '0;
                            state_reg <= RUN;
                        end
                    end
                end
                RUN: begin
                    // Dropping enable mid-division abandons it without touching outputs.
                    if (!enable) begin
                        state_reg <= IDLE;
                    end else begin
                        q_reg   <= q_next;
                        rem_reg <= rem_next;
                        cnt_reg <= cnt_reg + 1'b1;
                        if (cnt_reg == CW'(WIDTH - 1)) begin
                            result_reg    <= q_next;
`ifdef DIVDIV_REMAINDER_EN
                            remainder_reg <= rem_next;
`endif
                            state_reg     <= IDLE;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign result = result_reg;
`ifdef DIVDIV_REMAINDER_EN
    assign remainder = remainder_reg;
`endif

endmodule

// File: tb/tb_div_div.sv
// Directed self-checking bench for div_div (WIDTH=32); remainder checked when
// DIVDIV_REMAINDER_EN is defined.
module tb_div_div;

    logic        clk = 1'b0;
    logic        rstn;
    logic        enable;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic [31:0] result;
`ifdef DIVDIV_REMAINDER_EN
    logic [31:0] remainder;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    div_div #(.WIDTH(32)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .enable   (enable),
        .dividend (dividend),
        .divisor  (divisor),
`ifdef DIVDIV_REMAINDER_EN
        .remainder(remainder),
`endif
        .result   (result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic check_rem(input string tag, input logic [31:0] exp);
`ifdef DIVDIV_REMAINDER_EN
        check(tag, remainder, exp);
`endif
    endtask

    // One full transaction: rising enable, wait for the result, hold enable with
    // changed operands (must not restart), then drop enable.
    task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp_q, input logic [31:0] exp_r, input int hold);
        logic [31:0] prev;
        @(negedge clk);
        prev     = result;
        dividend = a;
        divisor  = b;
        enable   = 1'b1;
        if (b == 32'd0) begin
            @(posedge clk); #1;
        end else begin
            repeat (32) @(posedge clk);
            #1 check({tag, "_early"}, result, prev);
            @(posedge clk); #1;
        end
        check(tag, result, exp_q);
        check_rem({tag, "_rem"}, exp_r);
        @(negedge clk);
        dividend = a ^ 32'h0000_1000;
        divisor  = b + 32'd1;
        repeat (hold) @(negedge clk);
        check({tag, "_hold"}, result, exp_q);
        enable = 1'b0;
        repeat (4) @(negedge clk);
        check({tag, "_after"}, result, exp_q);
        check_rem({tag, "_after_rem"}, exp_r);
        $display("div %0d / %0d -> %0d (expected %0d)", a, b, result, exp_q);
    endtask

    initial begin
        rstn     = 1'b0;
        enable   = 1'b0;
        dividend = '0;
        divisor  = '0;
        #1000;
        check("reset", result, 32'd0);
        check_rem("reset_rem", 32'd0);
        @(negedge clk) rstn = 1'b1;
        repeat (20) @(negedge clk);
        check("idle", result, 32'd0);

        run_div("d8_1",    32'd8,    32'd1,  32'd8,  32'd0, 66);
        run_div("d56_7",   32'd56,   32'd7,  32'd8,  32'd0, 66);
        run_div("d107_10", 32'd107,  32'd10, 32'd10, 32'd7, 66);
        run_div("d3371_58", 32'd3371, 32'd58, 32'd58, 32'd7, 66);
        run_div("small",   32'd5,    32'd9,  32'd0,  32'd5, 10);
        run_div("equal",   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'd0, 10);
        run_div("max_2",   32'hFFFF_FFFF, 32'd2, 32'h7FFF_FFFF, 32'd1, 10);

        for (int d = 1; d <= 58; d += 3) begin
            logic [31:0] n;
            n = 32'(d * d + 7);
            run_div($sformatf("seq%0d", d), n, 32'(d), n / 32'(d), n % 32'(d), 66);
        end

        run_div("div0", 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 20);

        // Abort: enable drops after the 10th iteration edge.
        @(negedge clk);
        dividend = 32'd1000;
        divisor  = 32'd3;
        enable   = 1'b1;
        repeat (11) @(posedge clk);
        @(negedge clk) enable = 1'b0;
        repeat (40) @(negedge clk);
        check("abort", result, 32'hFFFF_FFFF);
        check_rem("abort_rem", 32'd5);
        $display("abort 1000 / 3 -> %0d (expected %0d)", result, 32'hFFFF_FFFF);

        // Operands changed mid-run are ignored.
        @(negedge clk);
        dividend = 32'd107;
        divisor  = 32'd10;
        enable   = 1'b1;
        repeat (5) @(negedge clk);
        dividend = 32'd999;
        divisor  = 32'd2;
        repeat (28) @(posedge clk);
        #1 check("opchg", result, 32'd10);
        check_rem("opchg_rem", 32'd7);
        @(negedge clk) enable = 1'b0;
        $display("opchg 107 / 10 -> %0d (expected 10)", result);

        // Asynchronous reset mid-division.
        repeat (3) @(negedge clk);
        dividend = 32'd3371;
        divisor  = 32'd58;
        enable   = 1'b1;
        repeat (10) @(posedge clk);
        #2 rstn = 1'b0;
        #1 check("async_rst", result, 32'd0);
        check_rem("async_rst_rem", 32'd0);
        enable = 1'b0;
        @(negedge clk) rstn = 1'b1;
        repeat (40) @(negedge clk);
        check("post_rst", result, 32'd0);
        $display("reset mid-run -> %0d (expected 0)", result);

        run_div("recover", 32'd56, 32'd7, 32'd8, 32'd0, 10);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
